// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: FSM encoding,
// slice width and the index-width helper.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int NIB_W = 4;

  // A single-nibble datapath still needs a 1-bit index register.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_add_sequencer_ks_add4_cin.sv
// Combinational 4-bit Kogge-Stone adder; the carry-in enters the prefix tree
// as generate bit -1, so position k of the tree is the carry into bit k.
module ks_add4_cin (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] p;
  logic [4:0] g0, p0, g1, p1, g2, g3;
  logic       p2_top;

  assign p  = a ^ b;
  assign g0 = {a & b, cin};
  assign p0 = {p, 1'b0};

  // Three prefix levels with spans 1, 2 and 4 cover all five positions.
  always_comb begin
    g1 = g0;
    p1 = p0;
    for (int k = 1; k < 5; k++) begin
      g1[k] = g0[k] | (p0[k] & g0[k-1]);
      p1[k] = p0[k] & p0[k-1];
    end
    g2 = g1;
    for (int k = 2; k < 5; k++) begin
      g2[k] = g1[k] | (p1[k] & g1[k-2]);
    end
    p2_top = p1[4] & p1[2];
    g3     = g2;
    g3[4]  = g2[4] | (p2_top & g2[0]);
  end

  assign s    = p ^ g3[3:0];
  assign cout = g3[4];

endmodule

// File: rtl/nibble_add_sequencer.sv
// WIDTH-bit add/subtract computed one nibble per clock, LSB first, through a
// single shared 4-bit slice, with valid/ready handshakes on both sides.
module nibble_add_sequencer
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = idx_width(NIB);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_next;
  logic [3:0]       a_nib, b_nib, s_nib;
  logic             c_nib;
  logic             last_pass;

  assign a_nib     = a_reg[int'(idx)*NIB_W +: NIB_W];
  assign b_nib     = b_reg[int'(idx)*NIB_W +: NIB_W];
  assign last_pass = (idx == LAST);

  ks_add4_cin u_slice (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry),
    .s    (s_nib),
    .cout (c_nib)
  );

  always_comb begin
    sum_next = sum_reg;
    sum_next[int'(idx)*NIB_W +: NIB_W] = s_nib;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (last_pass) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Subtraction is A + ~B + 1: the inverted operand is latched and the +1
  // rides in as the initial carry. Flags are frozen once the MSB nibble lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg   <= a;
            b_reg   <= sub ? ~b : b;
            carry   <= sub;
            idx     <= '0;
            sum_reg <= '0;
          end
        end
        RUN: begin
          sum_reg <= sum_next;
          carry   <= c_nib;
          cout    <= c_nib;
          idx     <= last_pass ? '0 : idx + 1'b1;
          if (last_pass) begin
            ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (s_nib[3] != a_reg[WIDTH-1]);
            zero <= (sum_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum = sum_reg;

endmodule

// File: tb/tb_nibble_add_sequencer.sv
// Self-checking bench: directed cases, backpressure, mid-op reset, WIDTH=4
// exhaustive sweep and a random WIDTH=16 regression against an arithmetic model.
module tb_nibble_add_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel16;
  logic        in_valid, out_ready, sub;
  logic [15:0] a, b;

  logic        in_ready16, out_valid16, cout16, ovf16, zero16, busy16;
  logic [15:0] sum16;
  logic        in_ready4, out_valid4, cout4, ovf4, zero4, busy4;
  logic [3:0]  sum4;

  logic        cur_in_ready, cur_out_valid, cur_cout, cur_ovf, cur_zero, cur_busy;
  logic [15:0] cur_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_add_sequencer #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & sel16),
    .in_ready  (in_ready16),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid16),
    .out_ready (out_ready & sel16),
    .sum       (sum16),
    .cout      (cout16),
    .ovf       (ovf16),
    .zero      (zero16),
    .busy      (busy16)
  );

  nibble_add_sequencer #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid & ~sel16),
    .in_ready  (in_ready4),
    .a         (a[3:0]),
    .b         (b[3:0]),
    .sub       (sub),
    .out_valid (out_valid4),
    .out_ready (out_ready & ~sel16),
    .sum       (sum4),
    .cout      (cout4),
    .ovf       (ovf4),
    .zero      (zero4),
    .busy      (busy4)
  );

  assign cur_in_ready  = sel16 ? in_ready16  : in_ready4;
  assign cur_out_valid = sel16 ? out_valid16 : out_valid4;
  assign cur_cout      = sel16 ? cout16      : cout4;
  assign cur_ovf       = sel16 ? ovf16       : ovf4;
  assign cur_zero      = sel16 ? zero16      : zero4;
  assign cur_busy      = sel16 ? busy16      : busy4;
  assign cur_sum       = sel16 ? sum16       : {12'b0, sum4};

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned result modulo 2^w, carry as "no unsigned overflow /
  // no borrow", overflow from the true signed result leaving the w-bit range.
  task automatic model(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                       input logic ts, output logic [15:0] es, output logic ec,
                       output logic eo, output logic ez);
    int full, ua, ub, sa, sb, r, u;
    full = 1 << w;
    ua   = int'(ta) & (full - 1);
    ub   = int'(tb_) & (full - 1);
    sa   = (ua >= full / 2) ? ua - full : ua;
    sb   = (ub >= full / 2) ? ub - full : ub;
    if (ts) begin
      u  = ua - ub;
      ec = (ua >= ub);
      r  = sa - sb;
    end else begin
      u  = ua + ub;
      ec = (u >= full);
      r  = sa + sb;
    end
    es = 16'(u & (full - 1));
    eo = (r < -(full / 2)) || (r >= full / 2);
    ez = (es == 16'h0);
  endtask

  // Starts and ends on a falling edge with the selected DUT idle.
  task automatic apply_stimulus(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                                input logic ts, input int in_gap, input int out_gap);
    int          lat;
    logic [15:0] es;
    logic        ec, eo, ez;
    sel16 = (w == 16);
    repeat (in_gap) @(negedge clk);
    check_output("in_ready_idle", 32'(cur_in_ready), 32'd1);
    a = ta; b = tb_; sub = ts; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat = 1;
    while (!cur_out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_output("latency", 32'(lat), 32'(w / 4 + 1));
    repeat (out_gap) @(negedge clk);
    model(w, ta, tb_, ts, es, ec, eo, ez);
    check_output("out_valid", 32'(cur_out_valid), 32'd1);
    check_output("in_ready_done", 32'(cur_in_ready), 32'd0);
    check_output("sum", 32'(cur_sum), 32'(es));
    check_output("cout", 32'(cur_cout), 32'(ec));
    check_output("ovf", 32'(cur_ovf), 32'(eo));
    check_output("zero", 32'(cur_zero), 32'(ez));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("out_valid_drop", 32'(cur_out_valid), 32'd0);
  endtask

  initial begin
    int n;
    sel16 = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0;
    a = '0; b = '0;
    #1;
    check_output("rst_sum", 32'(sum16), 32'd0);
    check_output("rst_flags", {28'd0, cout16, ovf16, zero16, out_valid16}, 32'd0);
    check_output("rst_busy", 32'(busy16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_output("rst_in_ready", 32'(in_ready16), 32'd1);

    apply_stimulus(16, 16'hFFFF, 16'h0001, 1'b0, 0, 0);
    apply_stimulus(16, 16'h0005, 16'h0007, 1'b1, 0, 0);
    apply_stimulus(16, 16'h7FFF, 16'h0001, 1'b0, 0, 0);

    // Backpressure: held result, fresh operands waiting on in_valid.
    sel16 = 1'b1;
    a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101;
    n = 0;
    while (!out_valid16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check_output("bp_valid", 32'(out_valid16), 32'd1);
      check_output("bp_sum", 32'(sum16), 32'h2345);
      check_output("bp_in_ready", 32'(in_ready16), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("bp_release_valid", 32'(out_valid16), 32'd0);
    check_output("bp_release_ready", 32'(in_ready16), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check_output("bp_second_busy", 32'(busy16), 32'd1);
    n = 0;
    while (!out_valid16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("bp_second_sum", 32'(sum16), 32'h1010);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset in the second RUN cycle.
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("midrst_sum", 32'(sum16), 32'd0);
    check_output("midrst_flags", {28'd0, cout16, ovf16, zero16, out_valid16}, 32'd0);
    check_output("midrst_busy", 32'(busy16), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(16, 16'h0001, 16'h0001, 1'b0, 0, 0);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 256; i++) begin
        apply_stimulus(4, 16'(i >> 4), 16'(i & 15), 1'(s), 0, 0);
      end
    end

    for (int i = 0; i < 1000; i++) begin
      apply_stimulus(16, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
